ma_stage: RTL and testbench

Memory-access stage of the 3PA pipeline. It sits directly downstream of the execute stage and consumes the EXMA register outputs: WB/MEM control, ALU result (address), Rs2 value, Rs2 address, PC and destination address. It performs byte/half/word loads and stores over a variable-latency data-memory handshake, stalls the front of the pipe while an access is outstanding, and registers its results into the MAWB pipeline register for the writeback stage.

---
 rtl/ma_stage.sv | 146 ++++++++++++++
 tb/tb_ma_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ma_stage.sv
// Memory-access stage: byte/half/word loads and stores into the MAWB pipeline register.
// Latency: 1 cycle on a zero-wait ack; N+1 cycles when the ack arrives N cycles after the request.
// Backpressure: o_MEM_Busy stalls upstream until the ack; i_MAWB_stall holds the MAWB register and keeps the request open.
module ma_stage #(
    parameter int WIDTH     = 32,
    parameter int WB_WIDTH  = 2,
    parameter int MA_WIDTH  = 5,
    parameter int RDS_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WB_WIDTH-1:0]  i_WB_Ctrl,
    input  logic [MA_WIDTH-1:0]  i_MEM_Ctrl,
    input  logic [WIDTH-1:0]     i_ALU_rslt,
    input  logic [WIDTH-1:0]     i_Rs2_val,
    input  logic [RDS_WIDTH-1:0] i_Rs2_addr,
    input  logic [RDS_WIDTH-1:0] i_Rds_addr,
    input  logic [WIDTH-1:0]     i_PC,
    input  logic                 i_Fwrd_Store,
    input  logic [WIDTH-1:0]     i_Data_From_WB,
    input  logic                 i_MAWB_flush,
    input  logic                 i_MAWB_stall,
    output logic                 o_DMem_Req,
    output logic                 o_DMem_We,
    output logic [WIDTH-1:0]     o_DMem_Addr,
    output logic [WIDTH-1:0]     o_DMem_WData,
    output logic [3:0]           o_DMem_BE,
    input  logic                 i_DMem_Ack,
    input  logic [WIDTH-1:0]     i_DMem_RData,
    output logic                 o_MEM_Busy,
    output logic                 o_Misaligned,
    output logic [WIDTH-1:0]     o_Data_To_EX,
    output logic [WB_WIDTH-1:0]  o_MAWB_WB,
    output logic [WIDTH-1:0]     o_MAWB_Mem_Data,
    output logic [WIDTH-1:0]     o_MAWB_ALU_rslt,
    output logic [RDS_WIDTH-1:0] o_MAWB_Rds_addr,
    output logic [WIDTH-1:0]     o_MAWB_PC
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state, state_nxt;
    logic             mem_rd, mem_wr, mem_op, ld_unsigned, misalign;
    logic [1:0]       size, ofs;
    logic [WIDTH-1:0] st_data, ld_data;
    logic [3:0]       st_be;
    logic             unused_ok;

    assign mem_rd       = i_MEM_Ctrl[0];
    assign mem_wr       = i_MEM_Ctrl[1];
    assign size         = i_MEM_Ctrl[3:2];
    assign ld_unsigned  = i_MEM_Ctrl[4];
    assign mem_op       = mem_rd | mem_wr;
    assign ofs          = i_ALU_rslt[1:0];
    assign o_Data_To_EX = i_ALU_rslt;
    assign unused_ok    = ^i_Rs2_addr;

    always_comb begin
        misalign = 1'b0;
        case (size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = ofs[0];
            default: misalign = (ofs != 2'b00);
        endcase
    end

    assign o_Misaligned = reset & mem_op & misalign;

    // Store data: lane-replicated so the memory only has to honour the byte enables.
    always_comb begin
        st_data = i_Fwrd_Store ? i_Data_From_WB : i_Rs2_val;
        st_be   = 4'b1111;
        case (size)
            2'b00: begin
                st_data = {4{st_data[7:0]}};
                st_be   = 4'b0001 << ofs;
            end
            2'b01: begin
                st_data = {2{st_data[15:0]}};
                st_be   = ofs[1] ? 4'b1100 : 4'b0011;
            end
            default: st_be = 4'b1111;
        endcase
    end

    always_comb begin
        logic [7:0]  ld_b;
        logic [15:0] ld_h;
        ld_b    = 8'(i_DMem_RData >> {ofs, 3'b000});
        ld_h    = ofs[1] ? i_DMem_RData[31:16] : i_DMem_RData[15:0];
        case (size)
            2'b00:   ld_data = {{(WIDTH-8){ld_b[7] & ~ld_unsigned}}, ld_b};
            2'b01:   ld_data = {{(WIDTH-16){ld_h[15] & ~ld_unsigned}}, ld_h};
            default: ld_data = i_DMem_RData;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // An ack seen while MAWB is stalled cannot be captured, so the access stays open.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (o_DMem_Req && !(i_DMem_Ack && !i_MAWB_stall)) state_nxt = S_WAIT;
            S_WAIT: if (i_DMem_Ack && !i_MAWB_stall)                  state_nxt = S_IDLE;
            default:                                                  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_DMem_Req   = reset & ((state == S_WAIT) | (mem_op & ~misalign));
        o_DMem_We    = mem_wr;
        o_DMem_Addr  = {i_ALU_rslt[WIDTH-1:2], 2'b00};
        o_DMem_WData = st_data;
        o_DMem_BE    = mem_wr ? st_be : 4'b1111;
        o_MEM_Busy   = o_DMem_Req & ~i_DMem_Ack;
    end

    always_ff @(posedge clk) begin
        if (!reset || i_MAWB_flush) begin
            o_MAWB_WB       <= '0;
            o_MAWB_Mem_Data <= '0;
            o_MAWB_ALU_rslt <= '0;
            o_MAWB_Rds_addr <= '0;
            o_MAWB_PC       <= '0;
        end else if (i_MAWB_stall) begin
            o_MAWB_WB       <= o_MAWB_WB;
        end else if (o_MEM_Busy || o_Misaligned) begin
            o_MAWB_WB       <= '0;
            o_MAWB_Mem_Data <= '0;
            o_MAWB_ALU_rslt <= '0;
            o_MAWB_Rds_addr <= '0;
            o_MAWB_PC       <= '0;
        end else begin
            o_MAWB_WB       <= i_WB_Ctrl;
            o_MAWB_Mem_Data <= mem_rd ? ld_data : '0;
            o_MAWB_ALU_rslt <= i_ALU_rslt;
            o_MAWB_Rds_addr <= i_Rds_addr;
            o_MAWB_PC       <= i_PC;
        end
    end

endmodule

// File: tb/tb_ma_stage.sv
// Directed and randomized bench for ma_stage with an arithmetic reference model of loads/stores.
module tb_ma_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  wb_ctrl;
    logic [4:0]  mem_ctrl;
    logic [31:0] alu_rslt, rs2_val, pc, data_from_wb, rdata;
    logic [4:0]  rs2_addr, rds_addr;
    logic        fwrd_store, flush, stall, ack;
    logic        dmem_req, dmem_we, mem_busy, misaligned;
    logic [31:0] dmem_addr, dmem_wdata, data_to_ex;
    logic [3:0]  dmem_be;
    logic [1:0]  mawb_wb;
    logic [31:0] mawb_mem_data, mawb_alu, mawb_pc;
    logic [4:0]  mawb_rds;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ma_stage dut (
        .clk(clk), .reset(reset),
        .i_WB_Ctrl(wb_ctrl), .i_MEM_Ctrl(mem_ctrl), .i_ALU_rslt(alu_rslt),
        .i_Rs2_val(rs2_val), .i_Rs2_addr(rs2_addr), .i_Rds_addr(rds_addr), .i_PC(pc),
        .i_Fwrd_Store(fwrd_store), .i_Data_From_WB(data_from_wb),
        .i_MAWB_flush(flush), .i_MAWB_stall(stall),
        .o_DMem_Req(dmem_req), .o_DMem_We(dmem_we), .o_DMem_Addr(dmem_addr),
        .o_DMem_WData(dmem_wdata), .o_DMem_BE(dmem_be),
        .i_DMem_Ack(ack), .i_DMem_RData(rdata),
        .o_MEM_Busy(mem_busy), .o_Misaligned(misaligned), .o_Data_To_EX(data_to_ex),
        .o_MAWB_WB(mawb_wb), .o_MAWB_Mem_Data(mawb_mem_data), .o_MAWB_ALU_rslt(mawb_alu),
        .o_MAWB_Rds_addr(mawb_rds), .o_MAWB_PC(mawb_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] w, input logic [4:0] m, input logic [31:0] a,
                          input logic [31:0] r2, input logic [4:0] rd, input logic [31:0] p,
                          input logic fw, input logic [31:0] wbd);
        wb_ctrl = w; mem_ctrl = m; alu_rslt = a; rs2_val = r2;
        rds_addr = rd; pc = p; fwrd_store = fw; data_from_wb = wbd;
        rs2_addr = 5'(r2);
    endtask

    function automatic int nbytes(input int sz);
        return (sz >= 2) ? 4 : (1 << sz);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                               input int sz, input bit uns);
        int nb;
        logic [31:0] mask, v;
        nb   = nbytes(sz);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        v    = (rd >> (8 * (a % 4))) & mask;
        if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input int sz);
        case (nbytes(sz))
            1:       return {24'h0, d[7:0]} * 32'h0101_0101;
            2:       return {16'h0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    int          kind, sz, nb, lat;
    bit          uns, fw, mis, memop;
    logic [1:0]  szb, w;
    logic [31:0] a, d2, dw, p, exp_be;
    logic [4:0]  rd;

    initial begin
        reset = 1'b0; flush = 1'b0; stall = 1'b0; ack = 1'b0; rdata = '0;
        set_op(2'b00, 5'b00000, '0, '0, '0, '0, 1'b0, '0);
        tick(); tick();
        check("rst_wb", 32'(mawb_wb), 32'h0);
        check("rst_memdata", mawb_mem_data, 32'h0);
        check("rst_alu", mawb_alu, 32'h0);
        check("rst_rds", 32'(mawb_rds), 32'h0);
        check("rst_pc", mawb_pc, 32'h0);
        check("rst_misaligned", 32'(misaligned), 32'h0);
        reset = 1'b1;

        set_op(2'b01, 5'b00000, 32'h1234, 32'h0, 5'd3, 32'h40, 1'b0, 32'h0);
        #2 check("alu_req", 32'(dmem_req), 32'h0);
        check("alu_fwd_ex", data_to_ex, 32'h1234);
        tick();
        check("alu_mawb_alu", mawb_alu, 32'h1234);
        check("alu_mawb_wb", 32'(mawb_wb), 32'h1);
        check("alu_mawb_mem", mawb_mem_data, 32'h0);
        check("alu_mawb_rds", 32'(mawb_rds), 32'h3);

        set_op(2'b11, 5'b00001, 32'h103, 32'h0, 5'd4, 32'h44, 1'b0, 32'h0);
        #2 check("lb_busy0", 32'(mem_busy), 32'h1);
        check("lb_addr", dmem_addr, 32'h100);
        check("lb_be", 32'(dmem_be), 32'hF);
        tick();
        check("lb_bubble1", 32'(mawb_wb), 32'h0);
        #2 check("lb_busy1", 32'(mem_busy), 32'h1);
        tick();
        check("lb_bubble2", 32'(mawb_wb), 32'h0);
        ack = 1'b1; rdata = 32'h80FF_0000;
        #2 check("lb_busy_ack", 32'(mem_busy), 32'h0);
        tick();
        check("lb_data", mawb_mem_data, 32'hFFFF_FF80);
        check("lb_wb", 32'(mawb_wb), 32'h3);

        set_op(2'b11, 5'b10101, 32'h102, 32'h0, 5'd5, 32'h48, 1'b0, 32'h0);
        ack = 1'b1; rdata = 32'hBEEF_1234;
        #2 check("lhu_busy", 32'(mem_busy), 32'h0);
        check("lhu_req", 32'(dmem_req), 32'h1);
        tick();
        check("lhu_data", mawb_mem_data, 32'h0000_BEEF);

        set_op(2'b00, 5'b00010, 32'h201, 32'hAB, 5'd0, 32'h4C, 1'b1, 32'h55);
        #2 check("sb_addr", dmem_addr, 32'h200);
        check("sb_wdata", dmem_wdata, 32'h5555_5555);
        check("sb_be", 32'(dmem_be), 32'h2);
        check("sb_we", 32'(dmem_we), 32'h1);
        tick();
        ack = 1'b0;

        set_op(2'b11, 5'b01001, 32'h102, 32'h0, 5'd6, 32'h50, 1'b0, 32'h0);
        #2 check("lw_mis_pulse", 32'(misaligned), 32'h1);
        check("lw_mis_req", 32'(dmem_req), 32'h0);
        tick();
        check("lw_mis_wb", 32'(mawb_wb), 32'h0);

        set_op(2'b11, 5'b01001, 32'h300, 32'h0, 5'd7, 32'h54, 1'b0, 32'h0);
        tick();
        reset = 1'b0;
        #2 check("rstwait_req", 32'(dmem_req), 32'h0);
        tick();
        check("rstwait_wb", 32'(mawb_wb), 32'h0);
        check("rstwait_pc", mawb_pc, 32'h0);
        reset = 1'b1;
        #2 check("rstwait_rereq", 32'(dmem_req), 32'h1);
        tick();
        ack = 1'b1; stall = 1'b1; rdata = 32'hCAFE_F00D;
        #2 check("stall_busy", 32'(mem_busy), 32'h0);
        tick();
        check("stall_req_held", 32'(dmem_req), 32'h1);
        check("stall_mawb_hold", 32'(mawb_wb), 32'h0);
        stall = 1'b0;
        tick();
        check("stall_done_data", mawb_mem_data, 32'hCAFE_F00D);
        check("stall_done_pc", mawb_pc, 32'h54);
        ack = 1'b0;

        set_op(2'b01, 5'b00000, 32'h77, 32'h0, 5'd8, 32'h58, 1'b0, 32'h0);
        flush = 1'b1;
        tick();
        check("flush_wb", 32'(mawb_wb), 32'h0);
        check("flush_alu", mawb_alu, 32'h0);
        flush = 1'b0;

        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 2);
            sz   = $urandom_range(0, 3);
            szb  = 2'(sz);
            uns  = 1'($urandom_range(0, 1));
            fw   = 1'($urandom_range(0, 1));
            nb   = nbytes(sz);
            a    = $urandom;
            if ($urandom_range(0, 5) != 0) a = a - (a % nb);
            memop = (kind != 0);
            mis   = memop && ((a % nb) != 0);
            lat   = $urandom_range(0, 3);
            w     = 2'($urandom);
            d2    = $urandom; dw = $urandom; p = $urandom; rd = 5'($urandom);
            rdata = $urandom;
            set_op(w, {uns, szb, kind == 2, kind == 1}, a, d2, rd, p, fw, dw);
            ack = memop && !mis && lat == 0;
            #2 check("rnd_req", 32'(dmem_req), 32'(memop && !mis));
            check("rnd_mis", 32'(misaligned), 32'(mis));
            if (memop && !mis) begin
                exp_be = (kind == 2) ? ((((32'h1 << nb) - 1) << (a % 4)) & 32'hF) : 32'hF;
                check("rnd_addr", dmem_addr, a & 32'hFFFF_FFFC);
                check("rnd_we", 32'(dmem_we), 32'(kind == 2));
                check("rnd_be", 32'(dmem_be), exp_be);
                check("rnd_busy", 32'(mem_busy), 32'(lat != 0));
                if (kind == 2) check("rnd_wdata", dmem_wdata, model_wdata(fw ? dw : d2, sz));
                for (int k = 1; k <= lat; k++) begin
                    tick();
                    check("rnd_bubble", 32'(mawb_wb), 32'h0);
                    ack = (k == lat);
                    #2 check("rnd_busy_wait", 32'(mem_busy), 32'(k != lat));
                end
            end
            tick();
            check("rnd_wb", 32'(mawb_wb), mis ? 32'h0 : 32'(w));
            if (!mis) begin
                check("rnd_memdata", mawb_mem_data, (kind == 1) ? model_load(rdata, a, sz, uns) : 32'h0);
                check("rnd_alu", mawb_alu, a);
                check("rnd_pc", mawb_pc, p);
                check("rnd_rds", 32'(mawb_rds), 32'(rd));
            end
            ack = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
